// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer
//   Drives an external registered-read ROM through a burst of consecutive
//   addresses, with the address wrapping modulo 2**ADDR_W. The ROM's 1-cycle
//   read latency is absorbed here, and the words are streamed downstream on a
//   valid/ready interface through a small FIFO.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   start                     begin burst; sampled only while idle
//   start_addr, burst_len     burst parameters; burst_len 0 means 2**ADDR_W
//   rom_addr, rom_en          registered ROM address and read enable
//   rom_data                  ROM read data, valid one cycle after rom_en
//   out_data/valid/ready/last downstream stream (FIFO head)
//   busy, done                burst in progress / 1-cycle completion pulse
module rom_read_sequencer #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic                    rom_en_q, rom_en_d;
  logic                    en_last_q, en_last_d;   // read now on rom_en is the final one
  logic                    rd_vld_q, rd_vld_d;     // rom_data carries a read this cycle
  logic                    rd_last_q, rd_last_d;   // ...and it is the final one
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        issued_q, issued_d;
  logic [DATA_W-1:0]       data_mem_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]    last_mem_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    push;
  logic                    pop;
  logic                    final_rd;
  logic [CNT_W:0]          occupancy;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = 1'b0;
    en_last_d  = 1'b0;
    len_d      = len_q;
    issued_d   = issued_q;
    done_d     = 1'b0;
    final_rd   = 1'b0;

    push      = rd_vld_q;
    pop       = (count_q != '0) && out_ready;
    rd_vld_d  = rom_en_q;
    rd_last_d = en_last_q;

    // Credit covers FIFO entries plus both in-flight read stages; pops are
    // deliberately not credited so a read never lands in a full FIFO.
    occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(rom_en_q) + (CNT_W+1)'(rd_vld_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = (burst_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, burst_len};
          rom_addr_d = start_addr;
          rom_en_d   = 1'b1;
          issued_d   = LEN_W'(1);
          final_rd   = (burst_len == ADDR_W'(1));
          en_last_d  = final_rd;
          state_d    = final_rd ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (occupancy < (CNT_W+1)'(BUF_DEPTH)) begin
          rom_addr_d = rom_addr_q + 1'b1;
          rom_en_d   = 1'b1;
          issued_d   = issued_q + 1'b1;
          final_rd   = (issued_d == len_q);
          en_last_d  = final_rd;
          if (final_rd) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && last_mem_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      en_last_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      data_mem_q <= '{default: '0};
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      en_last_q  <= en_last_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (push) begin
        data_mem_q[wr_ptr_q] <= rom_data;
        last_mem_q[wr_ptr_q] <= rd_last_q;
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_en    = rom_en_q;
  assign out_data  = data_mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_last  = out_valid & last_mem_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// tb_rom_read_sequencer
//   Drives rom_read_sequencer against a behavioural 8x8 registered-read ROM.
//   On each accepted start, the reference model precomputes the full expected
//   address and beat streams from the burst parameters and the ROM contents.
//   It then checks handshakes, rom_en cycles, busy/done, first-beat latency
//   and output stability under backpressure.
module tb_rom_read_sequencer;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int          DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] burst_len;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  rom_read_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM; output holds when en is low.
  logic [DATA_W-1:0] rom_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  int nvec = 0;
  int nerr = 0;

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W:0]   exp_beat_q [$];   // {last, data}
  logic              exp_busy  = 1'b0;
  logic              exp_done  = 1'b0;
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  int                lat        = -1;
  int                en_cycles  = 0;
  int                cyc        = 0;
  int                beats_seen = 0;
  int                first_hs   = 0;
  int                last_hs    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [DATA_W:0] b;
    logic            fin;
    logic            acc;
    int              l;
    logic [ADDR_W-1:0] a;
    cyc++;
    if (rst) begin
      exp_addr_q.delete();
      exp_beat_q.delete();
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      hold_prev = 1'b0;
      lat       = -1;
      return;
    end
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    if (lat >= 0) begin
      lat++;
      if (lat == 2) check("lat_early", out_valid, 0);
      if (lat == 3) begin
        check("lat_first", out_valid, 1);
        lat = -1;
      end
    end
    if (hold_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_last", out_last, prev_last);
    end
    if (rom_en) begin
      en_cycles++;
      if (exp_addr_q.size() == 0) check("rom_en_extra", rom_en, 0);
      else check("rom_addr", rom_addr, exp_addr_q.pop_front());
    end
    fin = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_beat_q.size() == 0) check("beat_extra", out_valid, 0);
      else begin
        b = exp_beat_q.pop_front();
        check("beat_data", out_data, b[DATA_W-1:0]);
        check("beat_last", out_last, b[DATA_W]);
        if (beats_seen == 0) first_hs = cyc;
        beats_seen++;
        if (b[DATA_W]) begin
          last_hs = cyc;
          fin = 1'b1;
        end
      end
    end
    acc = start && !exp_busy;
    if (acc) begin
      l = (burst_len == '0) ? DEPTH : int'(burst_len);
      for (int i = 0; i < l; i++) begin
        a = ADDR_W'((int'(start_addr) + i) % DEPTH);
        exp_addr_q.push_back(a);
        exp_beat_q.push_back({(i == l - 1), rom_mem[a]});
      end
      lat        = 0;
      beats_seen = 0;
    end
    exp_done = fin;
    if (fin) exp_busy = 1'b0;
    else if (acc) exp_busy = 1'b1;
    hold_prev = out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_rom_en"}, rom_en, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode: 0 = ready always high, 1 = random ready, 2 = stalled 20 cycles then high
  task automatic run_burst(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] bl,
                           input int mode, input bit mid);
    int n;
    int l;
    l = (bl == '0) ? DEPTH : int'(bl);
    n = 0;
    en_cycles  = 0;
    start      = 1'b1;
    start_addr = sa;
    burst_len  = bl;
    out_ready  = (mode == 2) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
    cycle();
    while (exp_busy) begin
      start      = (mid && n == 4);
      start_addr = start ? ADDR_W'(3) : ADDR_W'($urandom_range(0, 7));
      burst_len  = ADDR_W'($urandom_range(0, 7));
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) out_ready = (n >= 20);
      else out_ready = 1'b1;
      if (mode == 2 && n == 20) check("stall_reads", en_cycles, 4);
      cycle();
      n++;
      if (n > 300) begin
        check("burst_timeout", exp_busy, 0);
        break;
      end
    end
    start = 1'b0;
    cycle();   // done pulse is checked here
    check("beat_count", beats_seen, l);
    if (mode == 0) check("throughput", last_hs - first_hs, l - 1);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'(i + 1);
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    run_burst(3'd0, 3'd0, 0, 1'b0);   // full wrap-around burst
    run_burst(3'd6, 3'd4, 0, 1'b0);   // wraps 7 -> 0
    run_burst(3'd0, 3'd0, 2, 1'b0);   // long stall
    run_burst(3'd0, 3'd0, 0, 1'b1);   // mid-burst start ignored
    run_burst(3'd3, 3'd2, 0, 1'b0);
    run_burst(3'd5, 3'd1, 0, 1'b0);   // single beat

    // Reset after third beat.
    start = 1'b1; start_addr = 3'd2; burst_len = 3'd0; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (beats_seen < 3 && n < 50) begin
      cycle();
      n++;
    end
    check("pre_reset_beats", beats_seen, 3);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    run_burst(3'd2, 3'd0, 0, 1'b0);

    // Randomized bursts over random ROM contents.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'($urandom);
      for (int g = $urandom_range(0, 3); g > 0; g--) cycle();
      run_burst(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
